// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: per-stage hazard sources in, freeze/flush controls and debug status out.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W       = 4,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [REG_W-1:0]       src1;
    logic [REG_W-1:0]       src2;
    logic                   two_src;
    logic                   exe_wb_en;
    logic [REG_W-1:0]       exe_dest;
    logic                   exe_mem_r_en;
    logic                   mem_wb_en;
    logic [REG_W-1:0]       mem_dest;
    logic                   branch_taken;
    logic                   mem_access;
    logic                   mem_ready;
    logic                   freeze_pc;
    logic                   freeze_if_id;
    logic                   freeze_id_exe;
    logic                   freeze_exe_mem;
    logic                   freeze_mem_wb;
    logic                   flush_if_id;
    logic                   flush_id_exe;
    logic                   hazard;
    logic                   mem_err;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, src1, src2, two_src, exe_wb_en, exe_dest, exe_mem_r_en,
               mem_wb_en, mem_dest, branch_taken, mem_access, mem_ready,
        input  freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb,
               flush_if_id, flush_id_exe, hazard, mem_err, stall_cnt
    );

    modport slave (
        input  id_valid, src1, src2, two_src, exe_wb_en, exe_dest, exe_mem_r_en,
               mem_wb_en, mem_dest, branch_taken, mem_access, mem_ready,
        output freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb,
               flush_if_id, flush_id_exe, hazard, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/flush controller for the 5-stage pipeline (RAW, branch, SRAM wait, timeout halt).
// Optional macro FWD_EN: forwarding unit present, so only EXE load-use hazards stall.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hif
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]      WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0]      WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]      WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] CNT_ZERO  = {STALL_CNT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE   = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX   = {STALL_CNT_W{1'b1}};

    // Control vector layout: {freeze pc, if_id, id_exe, exe_mem, mem_wb, flush if_id, flush id_exe}
    localparam logic [6:0] CTL_NONE   = 7'b00000_00;
    localparam logic [6:0] CTL_FREEZE = 7'b11111_00;
    localparam logic [6:0] CTL_BRANCH = 7'b00000_11;
    localparam logic [6:0] CTL_BUBBLE = 7'b11000_01;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [WAIT_W-1:0]      wait_cnt_r;
    logic [WAIT_W-1:0]      wait_cnt_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   mem_err_r;
    logic                   mem_err_s;
    logic                   hazard_s;
    logic                   mstall_s;
    logic                   stall_inc_s;
    logic [6:0]             ctl_s;

    function automatic logic producer_match(input logic [REG_W-1:0] src,
                                            input logic [REG_W-1:0] dest,
                                            input logic             wb_en);
        return wb_en & (src == dest);
    endfunction

    // Branch flush outranks the hazard bubble; both are only taken when memory is not stalling.
    function automatic logic [6:0] run_ctl(input logic br, input logic hz);
        if (br) begin
            return CTL_BRANCH;
        end else if (hz) begin
            return CTL_BUBBLE;
        end else begin
            return CTL_NONE;
        end
    endfunction

    // Raw hazard detection on the ID-stage operands
    always_comb begin
`ifdef FWD_EN
        hazard_s = hif.id_valid & hif.exe_mem_r_en & hif.exe_wb_en &
                   ((hif.src1 == hif.exe_dest) | (hif.two_src & (hif.src2 == hif.exe_dest)));
`else
        hazard_s = hif.id_valid &
                   (producer_match(hif.src1, hif.exe_dest, hif.exe_wb_en) |
                    producer_match(hif.src1, hif.mem_dest, hif.mem_wb_en) |
                    (hif.two_src &
                     (producer_match(hif.src2, hif.exe_dest, hif.exe_wb_en) |
                      producer_match(hif.src2, hif.mem_dest, hif.mem_wb_en))));
`endif
    end

    assign mstall_s = hif.mem_access & ~hif.mem_ready;

    // Next-state and freeze/flush decode; every output forced quiet while rst is held
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        mem_err_s  = mem_err_r;
        ctl_s      = CTL_NONE;
        if (rst) begin
            ctl_s = CTL_NONE;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mstall_s) begin
                        ctl_s      = CTL_FREEZE;
                        state_s    = ST_MEM_WAIT;
                        wait_cnt_s = WAIT_ONE;
                    end else begin
                        ctl_s = run_ctl(hif.branch_taken, hazard_s);
                    end
                end
                ST_MEM_WAIT: begin
                    // The MEM-stage access is held, so only mem_ready matters here
                    if (hif.mem_ready) begin
                        ctl_s      = run_ctl(hif.branch_taken, hazard_s);
                        state_s    = ST_RUN;
                        wait_cnt_s = WAIT_ZERO;
                    end else if (wait_cnt_r < WAIT_MAX) begin
                        ctl_s      = CTL_FREEZE;
                        wait_cnt_s = wait_cnt_r + WAIT_ONE;
                    end else begin
                        ctl_s     = CTL_FREEZE;
                        state_s   = ST_HALT;
                        mem_err_s = 1'b1;
                    end
                end
                ST_HALT: begin
                    ctl_s     = CTL_FREEZE;
                    mem_err_s = 1'b1;
                end
                default: begin
                    ctl_s      = CTL_FREEZE;
                    state_s    = ST_RUN;
                    wait_cnt_s = WAIT_ZERO;
                end
            endcase
        end
    end

    assign stall_inc_s = ctl_s[6] & ((state_r == ST_RUN) | (state_r == ST_MEM_WAIT));

    // State, wait counter, sticky error and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= WAIT_ZERO;
            stall_cnt_r <= CNT_ZERO;
            mem_err_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            mem_err_r  <= mem_err_s;
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
        end
    end

    assign hif.freeze_pc      = ctl_s[6];
    assign hif.freeze_if_id   = ctl_s[5];
    assign hif.freeze_id_exe  = ctl_s[4];
    assign hif.freeze_exe_mem = ctl_s[3];
    assign hif.freeze_mem_wb  = ctl_s[2];
    assign hif.flush_if_id    = ctl_s[1];
    assign hif.flush_id_exe   = ctl_s[0];
    assign hif.hazard         = hazard_s;
    assign hif.mem_err        = mem_err_r;
    assign hif.stall_cnt      = stall_cnt_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: dut_a uses default sizing, dut_b uses MEM_TIMEOUT=4, STALL_CNT_W=3.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    logic id_valid, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_access, mem_ready;
    logic [3:0] src1, src2, exe_dest, mem_dest;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] C_NONE = 7'b00000_00;
    localparam logic [6:0] C_FRZ  = 7'b11111_00;
    localparam logic [6:0] C_BR   = 7'b00000_11;
    localparam logic [6:0] C_HZ   = 7'b11000_01;
    // Expectations for hazards that forwarding removes
    localparam logic [6:0] C_HZ_NF = FWD ? C_NONE : C_HZ;
    localparam logic       H_NF    = FWD ? 1'b0 : 1'b1;
    localparam int         I_NF    = FWD ? 0 : 1;

    pipeline_hazard_ctrl_if #(.REG_W(4), .STALL_CNT_W(16)) hif_a ();
    pipeline_hazard_ctrl_if #(.REG_W(4), .STALL_CNT_W(3))  hif_b ();

    assign hif_a.id_valid = id_valid;         assign hif_b.id_valid = id_valid;
    assign hif_a.src1 = src1;                 assign hif_b.src1 = src1;
    assign hif_a.src2 = src2;                 assign hif_b.src2 = src2;
    assign hif_a.two_src = two_src;           assign hif_b.two_src = two_src;
    assign hif_a.exe_wb_en = exe_wb_en;       assign hif_b.exe_wb_en = exe_wb_en;
    assign hif_a.exe_dest = exe_dest;         assign hif_b.exe_dest = exe_dest;
    assign hif_a.exe_mem_r_en = exe_mem_r_en; assign hif_b.exe_mem_r_en = exe_mem_r_en;
    assign hif_a.mem_wb_en = mem_wb_en;       assign hif_b.mem_wb_en = mem_wb_en;
    assign hif_a.mem_dest = mem_dest;         assign hif_b.mem_dest = mem_dest;
    assign hif_a.branch_taken = branch_taken; assign hif_b.branch_taken = branch_taken;
    assign hif_a.mem_access = mem_access;     assign hif_b.mem_access = mem_access;
    assign hif_a.mem_ready = mem_ready;       assign hif_b.mem_ready = mem_ready;

    pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(64), .STALL_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .hif(hif_a.slave)
    );
    pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(4), .STALL_CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .hif(hif_b.slave)
    );

    typedef struct {
        string      name;
        bit         sel_b;
        logic [6:0] ctl;
        logic       hz;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ca    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: pops one expectation per checked cycle and compares mid-cycle
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] o_ctl;
        logic       o_hz;
        logic       o_err;
        logic [31:0] o_cnt;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.sel_b) begin
                o_ctl = {hif_b.freeze_pc, hif_b.freeze_if_id, hif_b.freeze_id_exe, hif_b.freeze_exe_mem,
                         hif_b.freeze_mem_wb, hif_b.flush_if_id, hif_b.flush_id_exe};
                o_hz  = hif_b.hazard;
                o_err = hif_b.mem_err;
                o_cnt = 32'(hif_b.stall_cnt);
            end else begin
                o_ctl = {hif_a.freeze_pc, hif_a.freeze_if_id, hif_a.freeze_id_exe, hif_a.freeze_exe_mem,
                         hif_a.freeze_mem_wb, hif_a.flush_if_id, hif_a.flush_id_exe};
                o_hz  = hif_a.hazard;
                o_err = hif_a.mem_err;
                o_cnt = 32'(hif_a.stall_cnt);
            end
            chk(e.name, "ctl", 32'(o_ctl), 32'(e.ctl));
            chk(e.name, "hazard", 32'(o_hz), 32'(e.hz));
            chk(e.name, "mem_err", 32'(o_err), 32'(e.err));
            chk(e.name, "stall_cnt", o_cnt, e.cnt);
        end
    end

    task automatic step(input string nm, input bit sb, input logic [6:0] c, input logic h,
                        input logic er, input int n);
        exp_t e;
        e.name = nm; e.sel_b = sb; e.ctl = c; e.hz = h; e.err = er; e.cnt = n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; branch_taken = 1'b0; mem_access = 1'b1; mem_ready = 1'b0;
        src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        @(posedge clk);
        #1;
        // Reset held against a pending memory stall
        step("rst_a", 1'b0, C_NONE, 1'b0, 1'b0, 0);
        step("rst_b", 1'b1, C_NONE, 1'b0, 1'b0, 0);
        rst = 1'b0; mem_access = 1'b0;
        step("post_rst_run", 1'b0, C_NONE, 1'b0, 1'b0, 0);
        mem_ready = 1'b1;

        id_valid = 1'b1; src1 = 4'd3; exe_wb_en = 1'b1; exe_dest = 4'd3;
        step("raw_exe", 1'b0, C_HZ_NF, H_NF, 1'b0, 0);
        ca += I_NF;
        exe_mem_r_en = 1'b1;
        step("raw_load", 1'b0, C_HZ, 1'b1, 1'b0, ca);
        ca += 1;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; src1 = 4'd5; mem_wb_en = 1'b1; mem_dest = 4'd5;
        step("raw_mem", 1'b0, C_HZ_NF, H_NF, 1'b0, ca);
        ca += I_NF;
        src1 = 4'd1; src2 = 4'd5;
        step("src2_unused", 1'b0, C_NONE, 1'b0, 1'b0, ca);
        two_src = 1'b1;
        step("src2_mem", 1'b0, C_HZ_NF, H_NF, 1'b0, ca);
        ca += I_NF;
        two_src = 1'b0; mem_wb_en = 1'b0; src1 = 4'd0; exe_dest = 4'd0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        step("reg0", 1'b0, C_HZ, 1'b1, 1'b0, ca);
        ca += 1;
        id_valid = 1'b0;
        step("id_invalid", 1'b0, C_NONE, 1'b0, 1'b0, ca);
        id_valid = 1'b1; branch_taken = 1'b1;
        step("branch_hz", 1'b0, C_BR, 1'b1, 1'b0, ca);
        id_valid = 1'b0;
        step("branch", 1'b0, C_BR, 1'b0, 1'b0, ca);
        branch_taken = 1'b0;

        // Five-cycle SRAM wait, released on the ready cycle
        mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("mem_wait", 1'b0, C_FRZ, 1'b0, 1'b0, ca + i);
        end
        ca += 5;
        mem_ready = 1'b1;
        step("mem_release", 1'b0, C_NONE, 1'b0, 1'b0, ca);
        mem_ready = 1'b0;
        step("mw_br_pre", 1'b0, C_FRZ, 1'b0, 1'b0, ca);
        ca += 1;
        mem_ready = 1'b1; branch_taken = 1'b1;
        step("mw_release_br", 1'b0, C_BR, 1'b0, 1'b0, ca);
        branch_taken = 1'b0; mem_ready = 1'b0;
        step("mw_hz_pre", 1'b0, C_FRZ, 1'b0, 1'b0, ca);
        ca += 1;
        mem_ready = 1'b1; id_valid = 1'b1;
        step("mw_release_hz", 1'b0, C_HZ, 1'b1, 1'b0, ca);
        ca += 1;
        id_valid = 1'b0; mem_ready = 1'b0;
        step("mw_rst_pre", 1'b0, C_FRZ, 1'b0, 1'b0, ca);
        ca += 1;
        // Reset mid-wait: quiet outputs, then RUN (MEM_WAIT would freeze with mem_ready low)
        rst = 1'b1;
        step("mw_rst", 1'b0, C_NONE, 1'b0, 1'b0, ca);
        rst = 1'b0; mem_access = 1'b0;
        step("mw_rst_run", 1'b0, C_NONE, 1'b0, 1'b0, 0);
        step("b_after_rst", 1'b1, C_NONE, 1'b0, 1'b0, 0);

        // Timeout on dut_b: four-cycle limit, halt after the fifth frozen cycle
        mem_access = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("tmo_wait", 1'b1, C_FRZ, 1'b0, 1'b0, i);
        end
        step("tmo_halt", 1'b1, C_FRZ, 1'b0, 1'b1, 5);
        mem_ready = 1'b1;
        step("halt_ready", 1'b1, C_FRZ, 1'b0, 1'b1, 5);
        mem_access = 1'b0;
        step("halt_idle", 1'b1, C_FRZ, 1'b0, 1'b1, 5);
        rst = 1'b1;
        step("halt_rst", 1'b1, C_NONE, 1'b0, 1'b1, 5);
        rst = 1'b0;
        step("halt_cleared", 1'b1, C_NONE, 1'b0, 1'b0, 0);

        // Saturation of the 3-bit counter on dut_b
        id_valid = 1'b1; src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("sat", 1'b1, C_HZ, 1'b1, 1'b0, (i > 7) ? 7 : i);
        end
        id_valid = 1'b0;
        step("sat_hold", 1'b1, C_NONE, 1'b0, 1'b0, 7);

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central freeze/flush controller for the 5-stage pipeline. It drives the freeze and flush inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers and the PC.
- Detects RAW data hazards in ID, taken branches resolved in EXE, and multi-cycle SRAM waits in MEM.
- Sequences stalls and bubbles from these events.
- Halts the pipeline on a memory timeout.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
REG_W, 4, register-address width
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before halt (>=2)
STALL_CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
src1  in  REG_W  ID source reg 1
src2  in  REG_W  ID source reg 2
two_src  in  1  ID instruction reads src2
exe_wb_en  in  1  EXE instruction writes back
exe_dest  in  REG_W  EXE destination
exe_mem_r_en  in  1  EXE instruction is a load
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  REG_W  MEM destination
branch_taken  in  1  taken branch resolved in EXE
mem_access  in  1  MEM stage issuing load/store
mem_ready  in  1  SRAM done this cycle
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID
freeze_id_exe  out  1  hold ID/EXE
freeze_exe_mem  out  1  hold EXE/MEM
freeze_mem_wb  out  1  hold MEM/WB
flush_if_id  out  1  clear IF/ID
flush_id_exe  out  1  clear ID/EXE (bubble)
hazard  out  1  data hazard detected (raw, ungated)
mem_err  out  1  sticky timeout flag
stall_cnt  out  STALL_CNT_W  stall cycles since reset

Behaviour:
- State, wait_cnt, stall_cnt and mem_err are registered. Freeze/flush outputs are combinational from state and inputs.
- Reset, sampled on clk:
  - state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
  - While rst=1, all freeze/flush outputs are forced to 0.
- hazard, without FWD_EN:
  - Asserted when id_valid and either operand matches a live producer.
  - Operand match: (src1==exe_dest & exe_wb_en) | (src1==mem_dest & mem_wb_en) | two_src & (same terms for src2).
- mstall = mem_access & ~mem_ready.
- State RUN, priorities in order:
  1. mstall: all five freezes=1, flushes=0. Next state MEM_WAIT, wait_cnt<=1.
  2. branch_taken: flush_if_id=1, flush_id_exe=1, no freeze. Branch wins over hazard.
  3. hazard: freeze_pc=1, freeze_if_id=1, flush_id_exe=1. Other freezes=0.
  4. Otherwise all outputs 0.
- State MEM_WAIT:
  - mem_ready=0 and wait_cnt<MEM_TIMEOUT:
    - all freezes=1, flushes=0.
    - wait_cnt++.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT:
    - all freezes=1.
    - next state HALT, mem_err<=1.
  - mem_ready=1:
    - outputs as RUN rules 2-4; a branch held in EXE is acted on this cycle.
    - next state RUN, wait_cnt<=0.
- State HALT:
  - all freezes=1, flushes=0, mem_err=1.
  - Exit only via rst.
- A flush and a freeze on the same register are never asserted together.
- stall_cnt increments on every cycle with freeze_pc=1 in RUN or MEM_WAIT.
  - Saturates at all-ones.
  - Frozen in HALT and during rst.
- Reset mid-MEM_WAIT returns to RUN the next cycle, with outputs 0 while rst is held.
- Register 0 is not special: matches on dest 0 still stall.

Optional Feature:
FWD_EN: forwarding unit present.
- Defined:
  - hazard = id_valid & exe_mem_r_en & exe_wb_en & (src1==exe_dest | two_src & src2==exe_dest). Load-use only.
  - MEM-stage matches are ignored.
- Undefined: full RAW detection as above.
- All other behaviour is identical either way.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_access=1, mem_ready=0 -> all freeze/flush 0, stall_cnt=0, mem_err=0, state RUN after release.
- RAW hazard: id_valid=1, src1=3, exe_wb_en=1, exe_dest=3 for 1 cycle -> freeze_pc=1, freeze_if_id=1, flush_id_exe=1, stall_cnt 0->1. With FWD_EN and exe_mem_r_en=0 -> no hazard; with exe_mem_r_en=1 -> same stall.
- Branch+hazard same cycle: branch_taken=1, hazard condition true -> flush_if_id=1, flush_id_exe=1, freeze_pc=0.
- Memory wait: mem_access=1, mem_ready low 5 cycles then high -> all freezes=1 for 5 cycles, released on the ready cycle, stall_cnt +5, state back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> HALT entered after 5th frozen cycle, mem_err=1 sticky, freezes stay 1 after mem_ready=1, cleared only by rst.
- Saturation: STALL_CNT_W=3, 10 hazard cycles -> stall_cnt stops at 7.
